// File: rtl/piso_scan_ctrl_pkg.sv
// Shared definitions for the PISO scan-chain controller.
//
// Contents:
//   state_t        FSM state encoding used by piso_scan_ctrl
//   WIDTH_MIN/MAX  legal frame widths (8 per cascaded '165 stage, up to 64)
//   DIV_MIN        smallest legal shift-clock half-period in cp cycles
//   cnt_width()    counter width for a modulus, never narrower than 1 bit
package piso_scan_ctrl_pkg;

    typedef enum logic [2:0] {
        ST_IDLE     = 3'd0,
        ST_LOAD     = 3'd1,
        ST_SHIFT_LO = 3'd2,
        ST_SHIFT_HI = 3'd3,
        ST_DONE     = 3'd4
    } state_t;

    localparam int WIDTH_MIN = 1;
    localparam int WIDTH_MAX = 64;
    localparam int DIV_MIN   = 1;

    // A modulus of 1 still needs a 1-bit register so that port and
    // signal ranges never collapse to [-1:0].
    function automatic int cnt_width(input int n);
        return (n > 1) ? $clog2(n) : 1;
    endfunction

endpackage

// File: rtl/piso_tick_div.sv
// Phase timer for the shift-clock generator.
//
// Counts cp cycles inside one FSM phase and raises tick on the last cycle
// of every DIV-cycle phase. clear restarts the count so the cycle after a
// state change is always cycle 0 of the new phase.
//
// Ports:
//   cp     in   system clock, rising edge
//   mr_    in   asynchronous active-low reset
//   clear  in   next cycle starts a new phase
//   tick   out  current cycle is the last of the phase
module piso_tick_div
    import piso_scan_ctrl_pkg::*;
#(
    parameter int DIV = 1
) (
    input  logic cp,
    input  logic mr_,
    input  logic clear,
    output logic tick
);

    localparam int            CW   = cnt_width(DIV);
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] phase;

    // With DIV=1 the counter is pinned at 0 and every cycle is a tick.
    assign tick = (phase == LAST);

    always_ff @(posedge cp or negedge mr_) begin
        if (!mr_) begin
            phase <= '0;
        end else if (clear || tick) begin
            phase <= '0;
        end else begin
            phase <= phase + 1'b1;
        end
    end

endmodule

// File: rtl/piso_scan_ctrl.sv
// Sequencer for a '165-style parallel-in/serial-out register chain.
//
// A start request pulses the parallel-load line, then clocks the chain with
// a divided shift clock, sampling the serial output at the end of each
// low phase. The assembled frame (first-sampled bit in the MSB) is offered
// on a valid/ack handshake.
//
// Parameters:
//   WIDTH  bits per frame, 1..64 (8 per cascaded stage)
//   DIV    cp cycles per shift-clock half period, >=1
//
// Ports:
//   cp     in   system clock, rising edge
//   mr_    in   asynchronous active-low reset
//   start  in   frame request, honoured only in IDLE
//   abort  in   synchronous return to IDLE from any state
//   sin    in   serial data from the chain's last stage
//   pl_    out  parallel load to chain, active-low
//   sclk   out  shift clock to chain cp1
//   inh    out  clock inhibit to chain cp2, high = inhibit
//   busy   out  frame in progress (LOAD / SHIFT_LO / SHIFT_HI)
//   data   out  captured frame
//   valid  out  data holds a complete frame
//   ack    in   consumer takes data
//
// State table:
//   state    | meaning
//   IDLE     | chain quiet, waiting for start
//   LOAD     | pl_ low for DIV cycles, chain captures its parallel inputs
//   SHIFT_LO | sclk low for DIV cycles, sin sampled on the last cycle
//   SHIFT_HI | sclk high for DIV cycles, chain advances one bit
//   DONE     | frame presented with valid, waiting for ack
module piso_scan_ctrl
    import piso_scan_ctrl_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIV   = 1
) (
    input  logic             cp,
    input  logic             mr_,
    input  logic             start,
    input  logic             abort,
    input  logic             sin,
    output logic             pl_,
    output logic             sclk,
    output logic             inh,
    output logic             busy,
    output logic [WIDTH-1:0] data,
    output logic             valid,
    input  logic             ack
);

    localparam int            KW       = cnt_width(WIDTH);
    localparam logic [KW-1:0] LAST_BIT = KW'(WIDTH - 1);

    state_t        state;
    state_t        state_next;
    logic [KW-1:0] bit_cnt;
    logic          tick;
    logic          phase_clear;
    logic          last_bit;

    logic          pl_next;
    logic          sclk_next;
    logic          inh_next;
    logic          busy_next;
    logic          valid_next;

    assign last_bit    = (bit_cnt == LAST_BIT);
    assign phase_clear = (state_next != state);

    piso_tick_div #(
        .DIV (DIV)
    ) u_tick_div (
        .cp    (cp),
        .mr_   (mr_),
        .clear (phase_clear),
        .tick  (tick)
    );

    always_ff @(posedge cp or negedge mr_) begin
        if (!mr_) begin
            state <= ST_IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Outputs are decoded from the next state and then registered, so the
    // chain pins change on the same edge as the state and never glitch.
    always_comb begin
        state_next = state;
        if (abort) begin
            state_next = ST_IDLE;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (start) begin
                        state_next = ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    if (tick) begin
                        state_next = ST_SHIFT_LO;
                    end
                end
                ST_SHIFT_LO: begin
                    if (tick) begin
                        // No shift clock after the final sample.
                        state_next = last_bit ? ST_DONE : ST_SHIFT_HI;
                    end
                end
                ST_SHIFT_HI: begin
                    if (tick) begin
                        state_next = ST_SHIFT_LO;
                    end
                end
                ST_DONE: begin
                    if (ack) begin
                        state_next = ST_IDLE;
                    end
                end
                default: begin
                    state_next = ST_IDLE;
                end
            endcase
        end

        pl_next    = (state_next != ST_LOAD);
        sclk_next  = (state_next == ST_SHIFT_HI);
        inh_next   = !((state_next == ST_SHIFT_LO) || (state_next == ST_SHIFT_HI));
        busy_next  = (state_next == ST_LOAD) || (state_next == ST_SHIFT_LO) ||
                     (state_next == ST_SHIFT_HI);
        valid_next = (state_next == ST_DONE);
    end

    always_ff @(posedge cp or negedge mr_) begin
        if (!mr_) begin
            pl_   <= 1'b1;
            sclk  <= 1'b0;
            inh   <= 1'b1;
            busy  <= 1'b0;
            valid <= 1'b0;
        end else begin
            pl_   <= pl_next;
            sclk  <= sclk_next;
            inh   <= inh_next;
            busy  <= busy_next;
            valid <= valid_next;
        end
    end

    // Bit counter and shift register. data is not cleared at LOAD: a full
    // frame overwrites every bit, and an aborted frame leaves the partial
    // contents in place.
    always_ff @(posedge cp or negedge mr_) begin
        if (!mr_) begin
            bit_cnt <= '0;
            data    <= '0;
        end else begin
            if (abort || (state == ST_LOAD)) begin
                bit_cnt <= '0;
            end else if ((state == ST_SHIFT_HI) && tick) begin
                bit_cnt <= bit_cnt + 1'b1;
            end

            if (!abort && (state == ST_SHIFT_LO) && tick) begin
                // Truncating cast drops the old MSB; also covers WIDTH=1.
                data <= WIDTH'({data, sin});
            end
        end
    end

endmodule

// File: doc/piso_scan_ctrl.md
# piso_scan_ctrl

Sequencing controller for an 8-bit parallel-in/serial-out shift register chain (one or more cascaded '165-style stages). On a start request it pulses the parallel-load line, clocks the chain with a divided shift clock, samples the serial output and presents the assembled word on a valid/ack handshake. It sits between the register chain's control pins (`pl_`, `cp1`, `cp2`, serial out) and the consuming synchronous logic.

## Interface
- `WIDTH`, 8: bits per frame, 1..64; 8 × number of cascaded stages.
- `DIV`, 1: `cp` cycles per shift-clock half period, ≥1.

Ports:
- `cp`  in  1  system clock, rising edge.
- `mr_`  in  1  reset, asynchronous, active-low.
- `start`  in  1  frame request; sampled only in IDLE.
- `abort`  in  1  synchronous abort, any state → IDLE.
- `sin`  in  1  serial data from the chain's last-stage `out`.
- `pl_`  out  1  parallel load to chain, active-low.
- `sclk`  out  1  shift clock to chain `cp1`.
- `inh`  out  1  clock inhibit to chain `cp2`, high = inhibit.
- `busy`  out  1  high in LOAD/SHIFT_LO/SHIFT_HI.
- `data`  out  WIDTH  captured frame, first-sampled bit in MSB.
- `valid`  out  1  `data` holds a complete frame.
- `ack`  in  1  consumer accepts `data`.

## Operation
- Reset (async, `mr_`=0): state IDLE; `pl_`=1, `sclk`=0, `inh`=1, `busy`=0, `valid`=0, `data`=0, counters 0.
- IDLE: `pl_`=1, `sclk`=0, `inh`=1. `start`=1 → LOAD.
- LOAD: `pl_`=0 for DIV cycles, `inh`=1, `sclk`=0 → SHIFT_LO, bit counter k=0.
- SHIFT_LO: `pl_`=1, `inh`=0, `sclk`=0 for DIV cycles. On the last cycle: `data` ← {`data`[WIDTH-2:0], `sin`}; k==WIDTH-1 → DONE, else → SHIFT_HI.
- SHIFT_HI: `sclk`=1 for DIV cycles, `inh`=0; then k←k+1, → SHIFT_LO.
- DONE: `valid`=1, `inh`=1, `sclk`=0, `data` stable. `ack`=1 → IDLE, `valid` drops next edge.
- Exactly WIDTH-1 rising `sclk` edges per frame; no edge after the last sample.
- `start` outside IDLE is ignored, not queued; `start` and `ack` together in DONE: ack honoured, start ignored.
- `abort`=1: next edge → IDLE, all outputs to reset values except `data`, which holds; abort wins over `ack` and `start`.
- `mr_` low mid-frame: immediate return to reset values; chain is reloaded by the next frame.
- WIDTH=1: LOAD → SHIFT_LO → DONE, zero `sclk` edges.

## Timing
- `start` sampled at edge t0: `pl_` low from t0 to t0+DIV.
- First sample at edge t0+2·DIV; sample n (0-based) at t0+2·DIV·(n+1).
- `valid` rises at edge t0+2·WIDTH·DIV (WIDTH=8, DIV=1: 16 cycles).
- All outputs registered; no combinational path from inputs to outputs.
- `sin` must be stable one `cp` cycle after each `sclk` falling edge / `pl_` rising edge; it is sampled ≥DIV cycles later.
- Minimum frame-to-frame spacing: 2·WIDTH·DIV + 2 cycles (DONE with immediate `ack`, one IDLE cycle).

## Structure
- Shared package: state encoding (IDLE, LOAD, SHIFT_LO, SHIFT_HI, DONE), `WIDTH`/`DIV` range-check constants.
- Sub-module `piso_tick_div`: phase counter of width clog2(DIV), emits a one-cycle `tick` on the last cycle of each DIV-cycle phase and clears on phase entry. FSM, bit counter and data register live in the top.

## Test plan
- WIDTH=8, DIV=1, chain model loaded with 8'hA5, `start` pulse → `pl_` low 1 cycle, 7 `sclk` edges, `valid` at t0+16, `data`=8'hA5.
- WIDTH=16, DIV=3, two cascaded chain models holding 8'h3C, 8'hF0 → `data`=16'h3CF0, `valid` at t0+96, `sclk` high/low 3 cycles each.
- `valid` held with `ack`=0 for 10 cycles while `start` toggles → `data` unchanged, no `pl_` pulse; `ack` → IDLE next edge.
- `abort` in SHIFT_HI at bit 4 → IDLE next edge, `sclk`=0, `inh`=1, `valid`=0; new `start` yields a correct frame 8'h5A.
- `mr_` pulsed low mid-SHIFT_LO (between edges) → outputs at reset values immediately; after release, `start` yields correct frame.
- WIDTH=1, DIV=2, `sin`=1 → no `sclk` edges, `valid` at t0+4, `data`=1'b1.
